// File: rtl/uart_host_ctrl.sv
// rtl/uart_host_ctrl.sv - t16450 bus master: register init, TX FIFO drain to THR, optional RBR drain
//
// Purpose:
//   After reset, programs IER, divisor latch and LCR of a t16450, then moves
//   bytes from a local TX FIFO into THR whenever LSR.THRE reports space.
//   All UART accesses use 3-cycle writes (SETUP/STROBE/HOLD) and 4-cycle reads
//   (SETUP/STROBE1/STROBE2/HOLD). Bus outputs are registered so the strobes are
//   glitch-free and drop to inactive as soon as reset_n is asserted.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   tx_data/tx_valid      byte stream into the TX FIFO
//   tx_ready              FIFO can accept a byte
//   fifo_count            FIFO occupancy
//   init_done             register programming finished (sticky until reset)
//   rx_data/rx_valid      received byte and one-cycle strobe (RX build only, else 0)
//   uart_cs_n/rd_n/wr_n   UART CPU-port strobes
//   uart_addr/wr_data     UART register address and write data
//   uart_rd_data          UART read data
//
// Configuration macro: UART_HOST_RX_EN
//   Defined: POLL also checks LSR.DR; RBR reads take priority over THR writes
//   and IDLE polls continuously. Undefined: rx_data/rx_valid are tied to 0.

module uart_host_ctrl #(
  parameter logic [15:0] DIVISOR    = 16'h0001,
  parameter logic [7:0]  LCR_VAL    = 8'h03,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          init_done,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic                          uart_cs_n,
  output logic                          uart_rd_n,
  output logic                          uart_wr_n,
  output logic [2:0]                    uart_addr,
  output logic [7:0]                    uart_wr_data,
  input  logic [7:0]                    uart_rd_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_POLL,
    S_TXWR,
    S_RXRD
  } state_t;

  state_t      state, state_n;
  logic [2:0]  step, step_n;
  logic [1:0]  phase, phase_n;
  logic        run, run_n;
  logic        init_done_n;
  logic        pop, rx_fire;
  logic [7:0]  rd_q;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic        push, fifo_empty, poll_req;

  logic        cs_d, rd_d, wr_d;
  logic [2:0]  addr_d;
  logic [7:0]  data_d;

  // ---------------- TX FIFO ----------------
  assign tx_ready   = (fifo_count != CW'(FIFO_DEPTH));
  assign push       = tx_valid && tx_ready;
  assign fifo_empty = (fifo_count == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef UART_HOST_RX_EN
  assign poll_req = 1'b1;
`else
  assign poll_req = !fifo_empty;
`endif

  // ---------------- FSM state register ----------------
  // run holds the FSM in INIT/step 0/SETUP for the first edge after reset so
  // that the first SETUP cycle starts on that edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_INIT;
      step      <= '0;
      phase     <= '0;
      run       <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state     <= state_n;
      step      <= step_n;
      phase     <= phase_n;
      run       <= run_n;
      init_done <= init_done_n;
    end
  end

  // LSR/RBR sample at the end of STROBE2 of any read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q <= '0;
    end else if (run && (state == S_POLL || state == S_RXRD) && phase == 2'd2) begin
      rd_q <= uart_rd_data;
    end
  end

  // ---------------- FSM next state ----------------
  always_comb begin
    state_n     = state;
    step_n      = step;
    phase_n     = phase;
    run_n       = 1'b1;
    init_done_n = init_done;
    pop         = 1'b0;
    rx_fire     = 1'b0;
    if (run) begin
      case (state)
        S_INIT: begin
          if (phase == 2'd2) begin
            phase_n = '0;
            if (step == 3'd4) begin
              state_n     = S_IDLE;
              step_n      = '0;
              init_done_n = 1'b1;
            end else begin
              step_n = step + 3'd1;
            end
          end else begin
            phase_n = phase + 2'd1;
          end
        end
        S_IDLE: begin
          if (poll_req) begin
            state_n = S_POLL;
            phase_n = '0;
          end
        end
        S_POLL: begin
          if (phase == 2'd3) begin
            phase_n = '0;
`ifdef UART_HOST_RX_EN
            if (rd_q[0])                       state_n = S_RXRD;
            else if (rd_q[5] && !fifo_empty)   state_n = S_TXWR;
            else                               state_n = S_IDLE;
`else
            if (rd_q[5] && !fifo_empty)        state_n = S_TXWR;
            else                               state_n = S_IDLE;
`endif
          end else begin
            phase_n = phase + 2'd1;
          end
        end
        S_TXWR: begin
          if (phase == 2'd2) begin
            pop     = 1'b1;
            phase_n = '0;
            state_n = S_IDLE;
          end else begin
            phase_n = phase + 2'd1;
          end
        end
        S_RXRD: begin
          if (phase == 2'd3) begin
            rx_fire = 1'b1;
            phase_n = '0;
            state_n = S_IDLE;
          end else begin
            phase_n = phase + 2'd1;
          end
        end
        default: begin
          state_n = S_INIT;
          step_n  = '0;
          phase_n = '0;
        end
      endcase
    end
  end

  // ---------------- bus decode of the upcoming cycle ----------------
  always_comb begin
    cs_d   = 1'b1;
    rd_d   = 1'b1;
    wr_d   = 1'b1;
    addr_d = '0;
    data_d = '0;
    if (run_n) begin
      case (state_n)
        S_INIT: begin
          cs_d = 1'b0;
          wr_d = (phase_n != 2'd1);
          case (step_n)
            3'd0:    begin addr_d = 3'd1; data_d = 8'h00;          end
            3'd1:    begin addr_d = 3'd3; data_d = 8'h80;          end
            3'd2:    begin addr_d = 3'd0; data_d = DIVISOR[7:0];   end
            3'd3:    begin addr_d = 3'd1; data_d = DIVISOR[15:8];  end
            default: begin addr_d = 3'd3; data_d = LCR_VAL;        end
          endcase
        end
        S_POLL: begin
          cs_d   = 1'b0;
          addr_d = 3'd5;
          rd_d   = !(phase_n == 2'd1 || phase_n == 2'd2);
        end
        S_RXRD: begin
          cs_d   = 1'b0;
          addr_d = 3'd0;
          rd_d   = !(phase_n == 2'd1 || phase_n == 2'd2);
        end
        S_TXWR: begin
          cs_d   = 1'b0;
          addr_d = 3'd0;
          data_d = mem[rd_ptr];
          wr_d   = (phase_n != 2'd1);
        end
        default: begin
          cs_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uart_cs_n    <= 1'b1;
      uart_rd_n    <= 1'b1;
      uart_wr_n    <= 1'b1;
      uart_addr    <= '0;
      uart_wr_data <= '0;
    end else begin
      uart_cs_n    <= cs_d;
      uart_rd_n    <= rd_d;
      uart_wr_n    <= wr_d;
      uart_addr    <= addr_d;
      uart_wr_data <= data_d;
    end
  end

  // ---------------- RX presentation ----------------
`ifdef UART_HOST_RX_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= rx_fire;
      if (rx_fire) rx_data <= rd_q;
    end
  end
`else
  assign rx_data  = '0;
  assign rx_valid = 1'b0;
  logic unused_rx;
  assign unused_rx = ^{rd_q, rx_fire};
`endif

endmodule

// File: tb/tb_uart_host_ctrl.sv
// tb/tb_uart_host_ctrl.sv - scoreboard bench for uart_host_ctrl with a t16450 bus model

module tb_uart_host_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [4:0] fifo_count;
  logic       init_done;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       uart_cs_n, uart_rd_n, uart_wr_n;
  logic [2:0] uart_addr;
  logic [7:0] uart_wr_data;
  logic [7:0] uart_rd_data;

  uart_host_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .fifo_count(fifo_count), .init_done(init_done),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .uart_cs_n(uart_cs_n), .uart_rd_n(uart_rd_n), .uart_wr_n(uart_wr_n),
    .uart_addr(uart_addr), .uart_wr_data(uart_wr_data), .uart_rd_data(uart_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] addr; logic [7:0] data; int cyc; } wr_ev_t;
  typedef struct { logic [2:0] addr; int len; int cyc; } rd_ev_t;
  typedef struct { logic [2:0] addr; logic [7:0] data; } exp_t;

  wr_ev_t obs_wr[$];
  rd_ev_t obs_rd[$];
  exp_t   exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // UART model: LSR.THRE is 0 until busy_until LSR reads have completed;
  // LSR.DR is 1 while fewer than rbr_avail RBR reads have completed.
  int         cyc = 0;
  int         lsr_reads = 0, rbr_reads = 0, rx_pulses = 0;
  int         busy_until = 0, rbr_avail = 0;
  logic [7:0] rbr_val = 8'h00;
  logic [7:0] rx_last = 8'h00;
  logic       thre_m, dr_m;

  assign thre_m = (lsr_reads >= busy_until);
  assign dr_m   = (rbr_reads < rbr_avail);
  assign uart_rd_data = (uart_addr == 3'd5) ? {2'b00, thre_m, 4'b0000, dr_m} :
                        (uart_addr == 3'd0) ? rbr_val : 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  logic       prev_rd_n = 1'b1;
  int         rd_len = 0, rd_start = 0;
  logic [2:0] rd_addr = '0;

  always @(negedge clk) begin
    if (!uart_wr_n) obs_wr.push_back('{uart_addr, uart_wr_data, cyc});
    if (!uart_rd_n && prev_rd_n) begin
      rd_len = 1; rd_start = cyc; rd_addr = uart_addr;
    end else if (!uart_rd_n) begin
      rd_len = rd_len + 1;
    end
    if (uart_rd_n && !prev_rd_n) begin
      obs_rd.push_back('{rd_addr, rd_len, rd_start});
      if (rd_addr == 3'd5) lsr_reads = lsr_reads + 1;
      if (rd_addr == 3'd0) rbr_reads = rbr_reads + 1;
    end
    if (rx_valid) begin
      rx_pulses = rx_pulses + 1;
      rx_last   = rx_data;
    end
    prev_rd_n = uart_rd_n;
  end

  logic [2:0] ia [5] = '{3'd1, 3'd3, 3'd0, 3'd1, 3'd3};
  logic [7:0] id [5] = '{8'h00, 8'h80, 8'h01, 8'h00, 8'h03};

  task automatic do_reset();
    reset_n  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    obs_wr.delete(); obs_rd.delete(); exp_q.delete();
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    tx_data = b; tx_valid = 1'b1;
    exp_q.push_back('{3'd0, b});
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if ({uart_cs_n, uart_rd_n, uart_wr_n} !== 3'b111) $display("FAIL reset_strobes: got %b want 111", {uart_cs_n, uart_rd_n, uart_wr_n}); else n_pass++;
    n_checks++; if (uart_addr !== 3'd0) $display("FAIL reset_addr: got %0d want 0", uart_addr); else n_pass++;
    n_checks++; if (uart_wr_data !== 8'h00) $display("FAIL reset_wr_data: got %h want 00", uart_wr_data); else n_pass++;
    n_checks++; if (fifo_count !== 5'd0) $display("FAIL reset_count: got %0d want 0", fifo_count); else n_pass++;
    n_checks++; if (tx_ready !== 1'b1) $display("FAIL reset_tx_ready: got %b want 1", tx_ready); else n_pass++;
    n_checks++; if (init_done !== 1'b0) $display("FAIL reset_init_done: got %b want 0", init_done); else n_pass++;
    n_checks++; if ({rx_valid, rx_data} !== 9'h000) $display("FAIL reset_rx: got %b/%h want 0/00", rx_valid, rx_data); else n_pass++;
  endtask

  task automatic test_init();
    logic [13:0] got, want;
    for (int w = 0; w < 5; w++) exp_q.push_back('{ia[w], id[w]});
    reset_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (k <= 15) begin
        got  = {uart_cs_n, uart_wr_n, uart_rd_n, uart_addr, uart_wr_data};
        want = {1'b0, ((k - 1) % 3) != 1, 1'b1, ia[(k - 1) / 3], id[(k - 1) / 3]};
        n_checks++; if (got !== want) $display("FAIL init_bus_cycle%0d: got %h want %h", k, got, want); else n_pass++;
      end
      if (k == 15) begin
        n_checks++; if (init_done !== 1'b0) $display("FAIL init_done_early: got %b want 0 at edge 15", init_done); else n_pass++;
      end
      if (k == 16) begin
        n_checks++; if (init_done !== 1'b1) $display("FAIL init_done_edge16: got %b want 1", init_done); else n_pass++;
        n_checks++; if (uart_cs_n !== 1'b1) $display("FAIL init_idle_cs: got %b want 1", uart_cs_n); else n_pass++;
      end
    end
    while (exp_q.size() > 0) begin
      exp_t e = exp_q.pop_front();
      n_checks++;
      if (obs_wr.size() == 0) $display("FAIL init_sb: no write seen, want (%0d,%h)", e.addr, e.data);
      else begin
        wr_ev_t o = obs_wr.pop_front();
        if (o.addr !== e.addr || o.data !== e.data) $display("FAIL init_sb: got (%0d,%h) want (%0d,%h)", o.addr, o.data, e.addr, e.data); else n_pass++;
      end
    end
  endtask

  task automatic test_single_byte();
    int pcyc, k;
    busy_until = lsr_reads;
    @(negedge clk);
    obs_wr.delete(); obs_rd.delete();
    push_byte(8'h69);
    pcyc = cyc;
    n_checks++; if (fifo_count !== 5'd1) $display("FAIL single_count_up: got %0d want 1", fifo_count); else n_pass++;
    for (k = 0; k < 60 && obs_wr.size() == 0; k++) begin @(negedge clk); #1; end
    n_checks++;
    if (obs_wr.size() == 0) $display("FAIL single_write: timeout, got none want (0,69)");
    else begin
      wr_ev_t o = obs_wr.pop_front();
      exp_t e = exp_q.pop_front();
      if (o.addr !== e.addr || o.data !== e.data) $display("FAIL single_write: got (%0d,%h) want (%0d,%h)", o.addr, o.data, e.addr, e.data); else n_pass++;
`ifndef UART_HOST_RX_EN
      n_checks++; if (o.cyc != pcyc + 6) $display("FAIL single_latency: strobe at +%0d want +6", o.cyc - pcyc); else n_pass++;
      n_checks++; if (obs_rd.size() != 1 || obs_rd[0].addr !== 3'd5 || obs_rd[0].len != 2) $display("FAIL single_poll: got %0d reads want one 2-strobe read of addr 5", obs_rd.size()); else n_pass++;
      @(posedge clk); @(posedge clk); #1;
      n_checks++; if (fifo_count !== 5'd0) $display("FAIL single_count_down: got %0d want 0", fifo_count); else n_pass++;
`endif
    end
    exp_q.delete();
    repeat (4) @(posedge clk);
    n_checks++; if (fifo_count !== 5'd0) $display("FAIL single_drained: got %0d want 0", fifo_count); else n_pass++;
  endtask

  task automatic test_busy_poll();
    int k; logic gaps_ok;
    @(negedge clk);
    busy_until = lsr_reads + 3;
    obs_wr.delete(); obs_rd.delete();
    push_byte(8'h3C);
    for (k = 0; k < 100 && obs_wr.size() == 0; k++) begin @(negedge clk); #1; end
    n_checks++;
    if (obs_wr.size() == 0) $display("FAIL busy_write: timeout, got none want (0,3c)");
    else begin
      wr_ev_t o = obs_wr.pop_front();
      exp_t e = exp_q.pop_front();
      if (o.addr !== e.addr || o.data !== e.data) $display("FAIL busy_write: got (%0d,%h) want (%0d,%h)", o.addr, o.data, e.addr, e.data); else n_pass++;
    end
`ifndef UART_HOST_RX_EN
    gaps_ok = (obs_rd.size() == 4);
    for (int i = 1; i < obs_rd.size(); i++) if (obs_rd[i].cyc - obs_rd[i-1].cyc != 5 || obs_rd[i].addr !== 3'd5) gaps_ok = 1'b0;
    n_checks++; if (gaps_ok !== 1'b1) $display("FAIL busy_repoll: got %0d reads or bad spacing, want 4 LSR reads 5 cycles apart", obs_rd.size()); else n_pass++;
`endif
    repeat (12) @(posedge clk); #1;
    n_checks++; if (obs_wr.size() != 0) $display("FAIL busy_extra_write: got %0d extra writes want 0", obs_wr.size()); else n_pass++;
    n_checks++; if (fifo_count !== 5'd0) $display("FAIL busy_count: got %0d want 0", fifo_count); else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_overflow();
    int i, e, k; logic acc;
    do_reset();
    busy_until = 0;
    for (int w = 0; w < 5; w++) exp_q.push_back('{ia[w], id[w]});
    tx_data = 8'h10; tx_valid = 1'b1;
    reset_n = 1'b1;
    i = 0; e = 0;
    while (i < 17 && e < 300) begin
      acc = tx_ready;
      if (acc) exp_q.push_back('{3'd0, tx_data});
      @(posedge clk); #1; e++;
      if (e == 16) begin
        n_checks++; if (fifo_count !== 5'd16) $display("FAIL ovf_count16: got %0d want 16", fifo_count); else n_pass++;
        n_checks++; if (tx_ready !== 1'b0) $display("FAIL ovf_ready_full: got %b want 0", tx_ready); else n_pass++;
      end
      if (e == 17) begin
        n_checks++; if (tx_ready !== 1'b0) $display("FAIL ovf_hold_off: got %b want 0", tx_ready); else n_pass++;
      end
      if (acc) begin
        i++;
        if (i < 17) tx_data = 8'h10 + 8'(i); else tx_valid = 1'b0;
      end
      @(negedge clk);
    end
    tx_valid = 1'b0;
    n_checks++; if (i != 17) $display("FAIL ovf_push_timeout: got %0d pushes want 17", i); else n_pass++;
    for (k = 0; k < 400 && obs_wr.size() < 22; k++) @(negedge clk);
    #1;
    while (exp_q.size() > 0) begin
      exp_t x = exp_q.pop_front();
      n_checks++;
      if (obs_wr.size() == 0) $display("FAIL ovf_sb: no write seen, want (%0d,%h)", x.addr, x.data);
      else begin
        wr_ev_t o = obs_wr.pop_front();
        if (o.addr !== x.addr || o.data !== x.data) $display("FAIL ovf_sb: got (%0d,%h) want (%0d,%h)", o.addr, o.data, x.addr, x.data); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    busy_until = lsr_reads;
    push_byte(8'hA1);
    push_byte(8'hA2);
    exp_q.delete();
    for (k = 0; k < 60 && !(uart_wr_n === 1'b0 && uart_addr === 3'd0); k++) begin @(posedge clk); #1; end
    n_checks++; if (uart_wr_n !== 1'b0) $display("FAIL mid_strobe_seen: got wr_n %b want 0 (timeout)", uart_wr_n); else n_pass++;
    #1 reset_n = 1'b0;
    #1;
    n_checks++; if ({uart_wr_n, uart_cs_n} !== 2'b11) $display("FAIL mid_async_release: got wr_n/cs_n %b want 11", {uart_wr_n, uart_cs_n}); else n_pass++;
    n_checks++; if (fifo_count !== 5'd0) $display("FAIL mid_flush: got %0d want 0", fifo_count); else n_pass++;
    n_checks++; if (init_done !== 1'b0) $display("FAIL mid_init_done_clr: got %b want 0", init_done); else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    obs_wr.delete(); obs_rd.delete();
    for (int w = 0; w < 5; w++) exp_q.push_back('{ia[w], id[w]});
    reset_n = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    n_checks++; if (init_done !== 1'b1) $display("FAIL mid_reinit_done: got %b want 1", init_done); else n_pass++;
    while (exp_q.size() > 0) begin
      exp_t x = exp_q.pop_front();
      n_checks++;
      if (obs_wr.size() == 0) $display("FAIL mid_reinit_sb: no write seen, want (%0d,%h)", x.addr, x.data);
      else begin
        wr_ev_t o = obs_wr.pop_front();
        if (o.addr !== x.addr || o.data !== x.data) $display("FAIL mid_reinit_sb: got (%0d,%h) want (%0d,%h)", o.addr, o.data, x.addr, x.data); else n_pass++;
      end
    end
  endtask

  task automatic test_rx();
    int k, base, rbr_cyc;
    @(negedge clk);
    busy_until = lsr_reads;
    rbr_val    = 8'hA5;
    rbr_avail  = rbr_reads + 1;
    base       = rx_pulses;
    obs_wr.delete(); obs_rd.delete(); exp_q.delete();
    push_byte(8'h77);
    for (k = 0; k < 100 && obs_wr.size() == 0; k++) begin @(negedge clk); #1; end
    repeat (6) @(posedge clk); #1;
    n_checks++;
    if (obs_wr.size() == 0) $display("FAIL rx_thr_write: timeout, got none want (0,77)");
    else begin
      wr_ev_t o = obs_wr.pop_front();
      exp_t x = exp_q.pop_front();
      if (o.addr !== x.addr || o.data !== x.data) $display("FAIL rx_thr_write: got (%0d,%h) want (%0d,%h)", o.addr, o.data, x.addr, x.data); else n_pass++;
      rbr_cyc = -1;
      foreach (obs_rd[i]) if (obs_rd[i].addr == 3'd0 && rbr_cyc < 0) rbr_cyc = obs_rd[i].cyc;
`ifdef UART_HOST_RX_EN
      n_checks++; if (!(rbr_cyc >= 0 && rbr_cyc < o.cyc)) $display("FAIL rx_order: rbr read cyc %0d, thr write cyc %0d, want read first", rbr_cyc, o.cyc); else n_pass++;
`else
      n_checks++; if (rbr_cyc != -1) $display("FAIL rx_ignored_dr: got rbr read at cyc %0d want none", rbr_cyc); else n_pass++;
`endif
    end
`ifdef UART_HOST_RX_EN
    n_checks++; if (rx_pulses - base != 1) $display("FAIL rx_pulse_count: got %0d want 1", rx_pulses - base); else n_pass++;
    n_checks++; if (rx_last !== 8'hA5) $display("FAIL rx_data: got %h want a5", rx_last); else n_pass++;
`else
    n_checks++; if (rx_pulses - base != 0) $display("FAIL rx_tied_valid: got %0d pulses want 0", rx_pulses - base); else n_pass++;
    n_checks++; if (rx_data !== 8'h00) $display("FAIL rx_tied_data: got %h want 00", rx_data); else n_pass++;
`endif
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_init();
    test_single_byte();
    test_busy_poll();
    test_overflow();
    test_reset_mid();
    test_rx();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
